// File: rtl/song_player.sv
// -----------------------------------------------------------------------------
// song_player
//
// Plays one of three fixed 8-note melodies as a square wave when the sequencer
// presents a one-hot track select. Raises done at the end of the song and
// holds it until the sequencer releases cv back to 000.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous, active-low reset
//   fast      in   (only with SONG_PLAYER_TEMPO_EN) halve the length of notes
//                  started while high
//   cv[2:0]   in   track select: 100 = A, 010 = B, 001 = C, 000 = release/abort
//   spk       out  square-wave audio output
//   busy      out  high while a song is in progress (PLAY or GAP)
//   done      out  high after a completed song until cv returns to 000
//   note_idx  out  index of the current note, 0..7
//
// Optional feature macro: SONG_PLAYER_TEMPO_EN (adds the fast input).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module song_player #(
  parameter int unsigned NOTE_LEN   = 12500000,
  parameter int unsigned GAP_LEN    = 1250000,
  parameter int unsigned TONE_SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst,
`ifdef SONG_PLAYER_TEMPO_EN
  input  logic       fast,
`endif
  input  logic [2:0] cv,
  output logic       spk,
  output logic       busy,
  output logic       done,
  output logic [2:0] note_idx
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP, S_DONE} state_t;

  // Last count value of each timer (timers count 0..LEN-1).
  localparam int unsigned NOTE_HALF      = NOTE_LEN >> 1;
  localparam logic [31:0] NOTE_LAST      = 32'(NOTE_LEN - 1);
  localparam logic [31:0] NOTE_FAST_LAST = (NOTE_HALF == 0) ? 32'd0 : 32'(NOTE_HALF - 1);
  localparam logic [31:0] GAP_LAST       = (GAP_LEN == 0) ? 32'd0 : 32'(GAP_LEN - 1);

  // Song tables, note 0 in the least significant 3 bits.
  localparam logic [23:0] SONG_A = {3'd0, 3'd5, 3'd6, 3'd6, 3'd5, 3'd5, 3'd1, 3'd1};
  localparam logic [23:0] SONG_B = {3'd0, 3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd2, 3'd3};
  localparam logic [23:0] SONG_C = {3'd0, 3'd1, 3'd2, 3'd2, 3'd4, 3'd3, 3'd3, 3'd5};

  state_t      state_q, state_d;
  logic [2:0]  song_q, song_d;
  logic [2:0]  note_idx_q, note_idx_d;
  logic [31:0] note_cnt_q, note_cnt_d;
  logic [31:0] gap_cnt_q, gap_cnt_d;
  logic [31:0] div_cnt_q, div_cnt_d;
  logic        spk_q, spk_d;
`ifdef SONG_PLAYER_TEMPO_EN
  logic        fast_q, fast_d;
`endif

  logic [2:0]  note_code;
  logic [31:0] half_period;
  logic [31:0] note_last;
  logic        cv_onehot;
  logic        note_end;
  logic        gap_end;
  logic        last_note;

  function automatic logic [2:0] song_code(input logic [2:0] song, input logic [2:0] idx);
    logic [2:0] code;
    case (song)
      3'b100:  code = SONG_A[idx*3 +: 3];
      3'b010:  code = SONG_B[idx*3 +: 3];
      3'b001:  code = SONG_C[idx*3 +: 3];
      default: code = 3'd0;
    endcase
    return code;
  endfunction

  // Tone ROM with the configurable shift; a shifted-out value still needs at
  // least one cycle per half-period.
  function automatic logic [31:0] tone_hp(input logic [2:0] code);
    logic [31:0] rom;
    logic [31:0] hp;
    case (code)
      3'd1:    rom = 32'd95556;
      3'd2:    rom = 32'd85131;
      3'd3:    rom = 32'd75843;
      3'd4:    rom = 32'd71586;
      3'd5:    rom = 32'd63776;
      3'd6:    rom = 32'd56818;
      3'd7:    rom = 32'd50619;
      default: rom = 32'd0;
    endcase
    hp = rom >> TONE_SHIFT;
    if (hp == 32'd0) hp = 32'd1;
    return hp;
  endfunction

  always_comb begin
    note_code   = song_code(song_q, note_idx_q);
    half_period = tone_hp(note_code);
`ifdef SONG_PLAYER_TEMPO_EN
    note_last   = fast_q ? NOTE_FAST_LAST : NOTE_LAST;
`else
    note_last   = NOTE_LAST;
`endif
    cv_onehot   = (cv == 3'b100) || (cv == 3'b010) || (cv == 3'b001);
    note_end    = (note_cnt_q == note_last);
    gap_end     = (gap_cnt_q == GAP_LAST);
    last_note   = (note_idx_q == 3'd7);
  end

  always_comb begin
    state_d    = state_q;
    song_d     = song_q;
    note_idx_d = note_idx_q;
    note_cnt_d = note_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    div_cnt_d  = div_cnt_q;
    spk_d      = spk_q;
`ifdef SONG_PLAYER_TEMPO_EN
    fast_d     = fast_q;
`endif

    case (state_q)
      S_IDLE: begin
        spk_d = 1'b0;
        if (cv_onehot) begin
          state_d    = S_PLAY;
          song_d     = cv;
          note_idx_d = 3'd0;
          note_cnt_d = 32'd0;
          gap_cnt_d  = 32'd0;
          div_cnt_d  = 32'd0;
`ifdef SONG_PLAYER_TEMPO_EN
          fast_d     = fast;
`endif
        end
      end

      S_PLAY: begin
        // Abort wins over any note advance on the same edge.
        if (cv == 3'b000) begin
          state_d    = S_IDLE;
          song_d     = 3'b000;
          note_idx_d = 3'd0;
          note_cnt_d = 32'd0;
          gap_cnt_d  = 32'd0;
          div_cnt_d  = 32'd0;
          spk_d      = 1'b0;
        end else if (note_end) begin
          spk_d      = 1'b0;
          div_cnt_d  = 32'd0;
          note_cnt_d = 32'd0;
          gap_cnt_d  = 32'd0;
          if (GAP_LEN != 0) begin
            state_d = S_GAP;
          end else if (last_note) begin
            state_d = S_DONE;
          end else begin
            note_idx_d = note_idx_q + 3'd1;
`ifdef SONG_PLAYER_TEMPO_EN
            fast_d     = fast;
`endif
          end
        end else begin
          note_cnt_d = note_cnt_q + 32'd1;
          if (note_code == 3'd0) begin
            spk_d     = 1'b0;
            div_cnt_d = 32'd0;
          end else if (div_cnt_q == half_period - 32'd1) begin
            spk_d     = ~spk_q;
            div_cnt_d = 32'd0;
          end else begin
            div_cnt_d = div_cnt_q + 32'd1;
          end
        end
      end

      S_GAP: begin
        spk_d = 1'b0;
        if (cv == 3'b000) begin
          state_d    = S_IDLE;
          song_d     = 3'b000;
          note_idx_d = 3'd0;
          note_cnt_d = 32'd0;
          gap_cnt_d  = 32'd0;
          div_cnt_d  = 32'd0;
        end else if (gap_end) begin
          gap_cnt_d = 32'd0;
          if (last_note) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_PLAY;
            note_idx_d = note_idx_q + 3'd1;
            note_cnt_d = 32'd0;
            div_cnt_d  = 32'd0;
`ifdef SONG_PLAYER_TEMPO_EN
            fast_d     = fast;
`endif
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 32'd1;
        end
      end

      S_DONE: begin
        spk_d = 1'b0;
        // Only a release re-arms the player, so a held select never replays.
        if (cv == 3'b000) begin
          state_d    = S_IDLE;
          song_d     = 3'b000;
          note_idx_d = 3'd0;
        end
      end

      default: begin
        state_d = S_IDLE;
        spk_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      song_q     <= 3'b000;
      note_idx_q <= 3'd0;
      note_cnt_q <= 32'd0;
      gap_cnt_q  <= 32'd0;
      div_cnt_q  <= 32'd0;
      spk_q      <= 1'b0;
`ifdef SONG_PLAYER_TEMPO_EN
      fast_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      song_q     <= song_d;
      note_idx_q <= note_idx_d;
      note_cnt_q <= note_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      div_cnt_q  <= div_cnt_d;
      spk_q      <= spk_d;
`ifdef SONG_PLAYER_TEMPO_EN
      fast_q     <= fast_d;
`endif
    end
  end

  assign spk      = spk_q;
  assign note_idx = note_idx_q;
  assign busy     = (state_q == S_PLAY) || (state_q == S_GAP);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_song_player.sv
// -----------------------------------------------------------------------------
// tb_song_player
//
// Directed bench for song_player. dut_a: NOTE_LEN=64, GAP_LEN=4, TONE_SHIFT=12
// (song A half-periods 23,23,15,15,13,13,15,rest). dut_s: NOTE_LEN=8,
// GAP_LEN=0, TONE_SHIFT=16 (every half-period is 1 cycle).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_song_player;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_s;
  logic [2:0] cv_a, cv_s;
  logic       spk_a, busy_a, done_a;
  logic [2:0] idx_a;
  logic       spk_s, busy_s, done_s;
  logic [2:0] idx_s;
`ifdef SONG_PLAYER_TEMPO_EN
  logic       fast_a, fast_s;
  localparam int S_NOTE = 4;
`else
  localparam int S_NOTE = 8;
`endif
  localparam int S_TOTAL = 8 * S_NOTE;

  song_player #(.NOTE_LEN(64), .GAP_LEN(4), .TONE_SHIFT(12)) dut_a (
    .clk      (clk),
    .rst      (rst_a),
`ifdef SONG_PLAYER_TEMPO_EN
    .fast     (fast_a),
`endif
    .cv       (cv_a),
    .spk      (spk_a),
    .busy     (busy_a),
    .done     (done_a),
    .note_idx (idx_a)
  );

  song_player #(.NOTE_LEN(8), .GAP_LEN(0), .TONE_SHIFT(16)) dut_s (
    .clk      (clk),
    .rst      (rst_s),
`ifdef SONG_PLAYER_TEMPO_EN
    .fast     (fast_s),
`endif
    .cv       (cv_s),
    .spk      (spk_s),
    .busy     (busy_s),
    .done     (done_s),
    .note_idx (idx_s)
  );

  int checks = 0;
  int errors = 0;
  int bad;
  int n;
  int hp_a [8] = '{23, 23, 15, 15, 13, 13, 15, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges from the current point until spk_a first reads 1 (bounded).
  task automatic first_rise(output int edges);
    edges = 0;
    while (spk_a !== 1'b1 && edges < 200) begin
      tick();
      edges++;
    end
  endtask

  initial begin
    int nn, o, hp;
    logic exp_spk, exp_busy, exp_done;
    logic [2:0] exp_idx;

    rst_a = 1'b0;
    rst_s = 1'b0;
    cv_a  = 3'b000;
    cv_s  = 3'b000;
`ifdef SONG_PLAYER_TEMPO_EN
    fast_a = 1'b0;
    fast_s = 1'b1;
`endif
    tick();
    tick();
    chk("reset_spk",  {31'd0, spk_a},  0);
    chk("reset_busy", {31'd0, busy_a}, 0);
    chk("reset_done", {31'd0, done_a}, 0);
    chk("reset_idx",  {29'd0, idx_a},  0);
    chk("reset_s_busy", {31'd0, busy_s}, 0);
    rst_a = 1'b1;
    rst_s = 1'b1;
    tick();

    // ---- song A, full playback ----
    cv_a = 3'b100;
    tick();
    chk("a_start_busy", {31'd0, busy_a}, 1);
    chk("a_start_spk",  {31'd0, spk_a},  0);
    bad = 0;
    for (int k = 1; k <= 544; k++) begin
      tick();
      nn = k / 68;
      o  = k % 68;
      exp_busy = (k < 544);
      exp_done = (k >= 544);
      exp_idx  = (k < 544) ? nn[2:0] : 3'd7;
      if (k >= 544 || o == 0 || o >= 64) begin
        exp_spk = 1'b0;
      end else begin
        hp = hp_a[nn];
        exp_spk = (hp == 0) ? 1'b0 : ((o / hp) % 2 == 1);
      end
      if (spk_a !== exp_spk || busy_a !== exp_busy || done_a !== exp_done || idx_a !== exp_idx)
        bad++;
      if (k == 22)  chk("a_spk_low_before_hp", {31'd0, spk_a}, 0);
      if (k == 23)  chk("a_spk_first_rise",    {31'd0, spk_a}, 1);
      if (k == 67)  chk("a_idx_before_step",   {29'd0, idx_a}, 0);
      if (k == 68)  chk("a_idx_step",          {29'd0, idx_a}, 1);
      if (k == 151) chk("a_note2_rise",        {31'd0, spk_a}, 1);
      if (k == 543) chk("a_busy_last",         {31'd0, busy_a}, 1);
      if (k == 544) begin
        chk("a_done",      {31'd0, done_a}, 1);
        chk("a_busy_end",  {31'd0, busy_a}, 0);
        chk("a_idx_final", {29'd0, idx_a},  7);
      end
    end
    chk("a_trace_mismatches", bad, 0);

    // ---- DONE held with cv still 100: no replay ----
    bad = 0;
    repeat (50) begin
      tick();
      if (done_a !== 1'b1 || busy_a !== 1'b0 || spk_a !== 1'b0 || idx_a !== 3'd7) bad++;
    end
    chk("done_hold_mismatches", bad, 0);
    cv_a = 3'b000;
    tick();
    chk("release_done", {31'd0, done_a}, 0);
    chk("release_idx",  {29'd0, idx_a},  0);
    chk("release_busy", {31'd0, busy_a}, 0);

    // ---- non-one-hot selects ignored ----
    cv_a = 3'b011;
    repeat (3) tick();
    chk("cv011_busy", {31'd0, busy_a}, 0);
    chk("cv011_done", {31'd0, done_a}, 0);
    cv_a = 3'b111;
    repeat (3) tick();
    chk("cv111_busy", {31'd0, busy_a}, 0);
    chk("cv111_done", {31'd0, done_a}, 0);
    cv_a = 3'b000;
    tick();

    // ---- song B, with cv changed mid-song ----
    cv_a = 3'b010;
    tick();
    chk("b_start_busy", {31'd0, busy_a}, 1);
    first_rise(n);
    chk("b_note0_rise", n, 18);
    cv_a = 3'b100;
    repeat (50) tick();
    chk("b_idx1", {29'd0, idx_a}, 1);
    first_rise(n);
    chk("b_note1_rise", n, 20);
    repeat (48) tick();
    chk("b_idx2", {29'd0, idx_a}, 2);
    first_rise(n);
    chk("b_note2_rise", n, 23);
    cv_a = 3'b000;
    tick();
    chk("b_abort_busy", {31'd0, busy_a}, 0);
    tick();

    // ---- song C, abort at cycle 100 ----
    cv_a = 3'b001;
    tick();
    repeat (99) tick();
    chk("c_pre_abort_idx", {29'd0, idx_a}, 1);
    chk("c_pre_abort_spk", {31'd0, spk_a}, 1);
    cv_a = 3'b000;
    tick();
    chk("c_abort_busy", {31'd0, busy_a}, 0);
    chk("c_abort_spk",  {31'd0, spk_a},  0);
    chk("c_abort_idx",  {29'd0, idx_a},  0);
    chk("c_abort_done", {31'd0, done_a}, 0);
    repeat (5) tick();
    chk("c_abort_done_later", {31'd0, done_a}, 0);

    // ---- asynchronous reset mid-song ----
    cv_a = 3'b100;
    tick();
    repeat (30) tick();
    chk("r_pre_spk", {31'd0, spk_a}, 1);
    rst_a = 1'b0;
    #1;
    chk("r_async_spk",  {31'd0, spk_a},  0);
    chk("r_async_busy", {31'd0, busy_a}, 0);
    chk("r_async_idx",  {29'd0, idx_a},  0);
    chk("r_async_done", {31'd0, done_a}, 0);
    tick();
    tick();
    chk("r_held_busy", {31'd0, busy_a}, 0);
    rst_a = 1'b1;
    tick();
    chk("r_restart_busy", {31'd0, busy_a}, 1);
    chk("r_restart_idx",  {29'd0, idx_a},  0);
    first_rise(n);
    chk("r_restart_rise", n, 23);
    repeat (45) tick();
    chk("r_restart_idx1", {29'd0, idx_a}, 1);
    cv_a = 3'b000;
    tick();

    // ---- no-gap, HP = 1 instance ----
    cv_s = 3'b100;
    tick();
    chk("s_start_busy", {31'd0, busy_s}, 1);
    bad = 0;
    for (int k = 1; k <= S_TOTAL; k++) begin
      tick();
      nn = k / S_NOTE;
      o  = k % S_NOTE;
      exp_busy = (k < S_TOTAL);
      exp_done = (k >= S_TOTAL);
      exp_spk  = (k < S_TOTAL) && (nn < 7) && (o % 2 == 1);
      if (spk_s !== exp_spk || busy_s !== exp_busy || done_s !== exp_done) bad++;
      if (k == 1) chk("s_spk_toggle_hi", {31'd0, spk_s}, 1);
      if (k == 2) chk("s_spk_toggle_lo", {31'd0, spk_s}, 0);
      if (k == S_TOTAL - 1) chk("s_busy_last", {31'd0, busy_s}, 1);
      if (k == S_TOTAL) begin
        chk("s_done",     {31'd0, done_s}, 1);
        chk("s_idx_final", {29'd0, idx_s}, 7);
      end
    end
    chk("s_trace_mismatches", bad, 0);
    cv_s = 3'b000;
    tick();
    chk("s_release_done", {31'd0, done_s}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/song_player.md
Name: song_player

Overview:
- Datapath end of the play/done handshake driven by the game/menu sequencer.
- Receives a one-hot track select `cv`, plays the selected fixed 8-note melody as a square wave on `spk`, then holds `done` until the sequencer releases `cv`.
- Sits between the sequencer and the speaker pin.
- Internal tone ROM, note timer, gap timer and tone divider.

Parameters:
- NOTE_LEN, 12500000: cycles each note sounds (PLAY state), must be ≥1.
- GAP_LEN, 1250000: silent cycles after each note (GAP state); 0 means GAP is skipped.
- TONE_SHIFT, 0: right-shift applied to every half-period ROM value; a result of 0 is forced to 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cv  in  3  track select: 100 = song A, 010 = song B, 001 = song C, 000 = release.
- spk  out  1  square-wave audio output.
- busy  out  1  high while a song is in progress (PLAY or GAP).
- done  out  1  high in DONE until `cv` returns to 000.
- note_idx  out  3  index of the current note, 0..7.

Behaviour:
- One clock. Reset is asynchronous and active-low on `rst`. All state is registered.
- Reset values: state = IDLE, spk = 0, busy = 0, done = 0, note_idx = 0, all counters 0, song latch 0.
- Tone ROM: note code 0 = rest; codes 1..7 have half-periods 95556, 85131, 75843, 71586, 63776, 56818, 50619.
  - Effective half-period HP = code value >> TONE_SHIFT, min 1.
- Song tables (note codes for notes 0..7):
  - A = 1,1,5,5,6,6,5,0
  - B = 3,2,1,2,3,3,3,0
  - C = 5,3,3,4,2,2,1,0
- IDLE:
  - On the first edge where `cv` is exactly one-hot: latch the song, note_idx = 0, clear timers, go to PLAY, busy = 1 from that edge.
  - Values 000 and non-one-hot `cv` are ignored.
- PLAY:
  - Note timer counts NOTE_LEN cycles.
  - Non-rest note: the divider counts 0..HP-1 and toggles `spk` on the edge where it equals HP-1, then wraps to 0. `spk` is 0 at note start. A rest note holds `spk` = 0.
  - At the end of the note: `spk` = 0, go to GAP (or straight to the next note or DONE if GAP_LEN = 0).
- GAP:
  - `spk` = 0 for GAP_LEN cycles.
  - Then, if note_idx < 7: note_idx += 1, go to PLAY with the divider cleared.
  - If note_idx = 7: go to DONE.
- DONE:
  - busy = 0, done = 1, `spk` = 0, note_idx holds 7.
  - First edge with `cv` == 000: go to IDLE, done = 0, note_idx = 0.
- Total busy duration: 8·(NOTE_LEN + GAP_LEN) cycles.
- Abort: `cv` == 000 at any edge in PLAY or GAP → IDLE with `spk`, busy and note_idx all 0. done is not asserted.
- A change of `cv` to a different nonzero value mid-song is ignored; the latched song continues.
- Same-cycle events: the abort check takes priority over note/gap advance.
- Reset asserted mid-song returns everything to reset values immediately (asynchronous).

Optional Feature:
- Macro: SONG_PLAYER_TEMPO_EN.
- When defined:
  - Adds input port `fast` (1 bit).
  - `fast` is sampled at each note start. If it is 1, that note lasts NOTE_LEN>>1 cycles (min 1). GAP is unaffected.
- When undefined:
  - No `fast` port.
  - Every note lasts NOTE_LEN cycles.

Test Plan:
1. Reset, then NOTE_LEN=64, GAP_LEN=4, TONE_SHIFT=12, cv=100 held:
   - busy rises on the first edge and stays high 544 cycles.
   - `spk` first rises 23 cycles after start (HP = 23).
   - note_idx steps 0→7 every 68 cycles.
   - done = 1 after 544 cycles.
2. Same setup, in DONE with cv held at 100 for 50 cycles:
   - done stays 1, no replay.
   - cv → 000: done = 0 next edge, state IDLE.
   - cv=010 then starts song B; first note HP = 18.
3. cv=001, drop to 000 at cycle 100:
   - Next edge: busy = 0, `spk` = 0, note_idx = 0, done never asserted.
4. cv=011 and 111 in IDLE:
   - busy and done stay 0.
   - cv=100 mid-song-B changes nothing: B's codes continue.
5. Assert rst low at cycle 30 of song A:
   - All outputs 0 immediately.
   - After release with cv=100 held, playback restarts from note 0.
6. GAP_LEN=0, NOTE_LEN=8, TONE_SHIFT=16 (every HP = 1): `spk` toggles every cycle on non-rest notes, done after 64 cycles; with SONG_PLAYER_TEMPO_EN and fast=1, done after 32 cycles.
